matrix_multiply_controller: RTL and testbench



---
 rtl/matrix_multiply_controller_pkg.sv | 13 +
 rtl/matrix_multiply_controller_if.sv | 31 +++
 rtl/matrix_multiply_controller.sv | 154 +++++++++++++++
 tb/tb_matrix_multiply_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_multiply_controller_pkg.sv
// Shared definitions for the systolic array sequencer: FSM states and latency constants.
package mmu_pkg;

   typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

   localparam int READ_LAT = 1;

   // One buffer read cycle plus 2*LENGTH-1 cycles of array skew/propagation.
   function automatic int out_lat(input int length);
      return 2 * length;
   endfunction

endpackage

// File: rtl/matrix_multiply_controller_if.sv
// Host/buffer/array signal bundle around the matrix multiply sequencer.
interface matrix_multiply_controller_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  Start;
   logic [ADDR_WIDTH-1:0] NumRows;
   logic [ADDR_WIDTH-1:0] WeightBase;
   logic [ADDR_WIDTH-1:0] InputBase;
   logic                  Busy;
   logic                  Done;
   logic                  WeightRdEn;
   logic [ADDR_WIDTH-1:0] WeightRdAddr;
   logic                  Load;
   logic                  InputRdEn;
   logic [ADDR_WIDTH-1:0] InputRdAddr;
   logic                  EN;
   logic                  OutValid;
   logic [ADDR_WIDTH-1:0] OutAddr;

   modport master (
      output Start, NumRows, WeightBase, InputBase,
      input  Busy, Done, WeightRdEn, WeightRdAddr, Load, InputRdEn, InputRdAddr,
             EN, OutValid, OutAddr
   );

   modport slave (
      input  Start, NumRows, WeightBase, InputBase,
      output Busy, Done, WeightRdEn, WeightRdAddr, Load, InputRdEn, InputRdAddr,
             EN, OutValid, OutAddr
   );
endinterface

// File: rtl/matrix_multiply_controller.sv
// Sequencer for one systolic matrix job: weight preload, input streaming, result drain.
module matrix_multiply_controller
   import mmu_pkg::*;
#(
   parameter int LENGTH     = 256,
   parameter int ADDR_WIDTH = 16
) (
   input  logic CLK,
   input  logic SYNC_RST,
   matrix_multiply_controller_if.slave mmu
);

   localparam int KW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam int CW = ADDR_WIDTH + 2 + $clog2(out_lat(LENGTH));
   localparam logic [CW-1:0]         C_OUT_LAT = CW'(out_lat(LENGTH));
   localparam logic [ADDR_WIDTH-1:0] C_W_TOP   = ADDR_WIDTH'(LENGTH - 1);
   localparam logic [KW-1:0]         C_K_LAST  = KW'(LENGTH - 1);

   state_t                r_state;
   logic [KW-1:0]         r_k;
   logic [CW-1:0]         r_c;
   logic [ADDR_WIDTH-1:0] r_num;
   logic [ADDR_WIDTH-1:0] r_wbase;
   logic [ADDR_WIDTH-1:0] r_ibase;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_wrd_en;
   logic [ADDR_WIDTH-1:0] r_wrd_addr;
   logic                  r_in_en;
   logic [ADDR_WIDTH-1:0] r_in_addr;
   logic                  r_en;
   logic                  r_ov;
   logic [ADDR_WIDTH-1:0] r_out_addr;
   logic [READ_LAT-1:0]   r_load_pipe;

   logic [CW-1:0]         w_num;
   logic [CW-1:0]         w_c_inc;
   logic [CW-1:0]         w_c_last;
   logic                  w_ov_nxt;
   logic                  w_en_nxt;
   logic [READ_LAT:0]     w_load_sh;

   // c counts from the first input read; all result timing is a window on c.
   assign w_num     = CW'(r_num);
   assign w_c_inc   = r_c + CW'(1);
   assign w_c_last  = C_OUT_LAT + w_num - CW'(1);
   assign w_ov_nxt  = (w_c_inc >= C_OUT_LAT) && (w_c_inc < C_OUT_LAT + w_num);
   assign w_en_nxt  = (w_c_inc >= CW'(READ_LAT));
   assign w_load_sh = {r_load_pipe, r_wrd_en};

   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_c         <= '0;
         r_num       <= '0;
         r_wbase     <= '0;
         r_ibase     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_wrd_en    <= 1'b0;
         r_wrd_addr  <= '0;
         r_in_en     <= 1'b0;
         r_in_addr   <= '0;
         r_en        <= 1'b0;
         r_ov        <= 1'b0;
         r_out_addr  <= '0;
         r_load_pipe <= '0;
      end else begin
         r_load_pipe <= w_load_sh[READ_LAT-1:0];
         r_done      <= 1'b0;
         r_wrd_en    <= 1'b0;
         r_wrd_addr  <= '0;
         r_in_en     <= 1'b0;
         r_in_addr   <= '0;
         r_en        <= 1'b0;
         r_ov        <= 1'b0;
         r_out_addr  <= '0;
         unique case (r_state)
            IDLE: begin
               if (mmu.Start) begin
                  r_num   <= mmu.NumRows;
                  r_wbase <= mmu.WeightBase;
                  r_ibase <= mmu.InputBase;
                  r_busy  <= 1'b1;
                  if (mmu.NumRows == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= LOAD_W;
                     r_k        <= '0;
                     r_wrd_en   <= 1'b1;
                     r_wrd_addr <= mmu.WeightBase + C_W_TOP;
                  end
               end
            end
            LOAD_W: begin
               if (r_k == C_K_LAST) begin
                  r_state   <= COMPUTE;
                  r_c       <= '0;
                  r_in_en   <= 1'b1;
                  r_in_addr <= r_ibase;
                  r_en      <= (READ_LAT == 0);
               end else begin
                  r_k        <= r_k + KW'(1);
                  r_wrd_en   <= 1'b1;
                  // Bottom weight row first, so addresses count down from base+LENGTH-1.
                  r_wrd_addr <= r_wbase + C_W_TOP - ADDR_WIDTH'(r_k + KW'(1));
               end
            end
            COMPUTE: begin
               r_c  <= w_c_inc;
               r_en <= w_en_nxt;
               r_ov <= w_ov_nxt;
               if (w_ov_nxt) r_out_addr <= ADDR_WIDTH'(w_c_inc - C_OUT_LAT);
               if (r_c == w_num - CW'(1)) begin
                  r_state <= DRAIN;
               end else begin
                  r_in_en   <= 1'b1;
                  r_in_addr <= r_ibase + ADDR_WIDTH'(w_c_inc);
               end
            end
            DRAIN: begin
               if (r_c == w_c_last) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_c  <= w_c_inc;
                  r_en <= w_en_nxt;
                  r_ov <= w_ov_nxt;
                  if (w_ov_nxt) r_out_addr <= ADDR_WIDTH'(w_c_inc - C_OUT_LAT);
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mmu.Busy         = r_busy;
   assign mmu.Done         = r_done;
   assign mmu.WeightRdEn   = r_wrd_en;
   assign mmu.WeightRdAddr = r_wrd_addr;
   assign mmu.Load         = r_load_pipe[READ_LAT-1];
   assign mmu.InputRdEn    = r_in_en;
   assign mmu.InputRdAddr  = r_in_addr;
   assign mmu.EN           = r_en;
   assign mmu.OutValid     = r_ov;
   assign mmu.OutAddr      = r_out_addr;

endmodule

// File: tb/tb_matrix_multiply_controller.sv
// Scoreboard bench: a job-level timing model queues expected strobes, a negedge monitor checks them.
module tb_matrix_multiply_controller;

   localparam int L  = 4;
   localparam int AW = 16;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   busy_lo = 1;
   int   busy_hi = 0;
   bit   rst_prev = 1'b1;
   int   s;

   // 0 WeightRdEn, 1 Load, 2 InputRdEn, 3 EN, 4 OutValid, 5 Done
   ev_t q [6][$];

   matrix_multiply_controller_if #(.ADDR_WIDTH(AW)) mmu ();

   matrix_multiply_controller #(.LENGTH(L), .ADDR_WIDTH(AW)) dut (
      .CLK      (clk),
      .SYNC_RST (rst),
      .mmu      (mmu)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string qn(input int id);
      case (id)
         0: return "wrd_en";
         1: return "load";
         2: return "ird_en";
         3: return "en";
         4: return "out_valid";
         default: return "done";
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   // Expected strobe schedule for a job accepted at the edge ending cycle t.
   task automatic push_job(input int t, input int n, input logic [AW-1:0] wb, input logic [AW-1:0] ib);
      busy_lo = t + 1;
      if (n == 0) begin
         busy_hi = t + 1;
         q[5].push_back('{t + 1, AW'(0)});
         return;
      end
      busy_hi = t + 3*L + n + 1;
      for (int k = 0; k < L; k++) begin
         q[0].push_back('{t + 1 + k, wb + AW'(L - 1 - k)});
         q[1].push_back('{t + 2 + k, AW'(0)});
      end
      for (int i = 0; i < n; i++) begin
         q[2].push_back('{t + L + 1 + i, ib + AW'(i)});
         q[4].push_back('{t + L + 1 + i + 2*L, AW'(i)});
      end
      for (int c = t + L + 2; c <= t + 3*L + n; c++) q[3].push_back('{c, AW'(0)});
      q[5].push_back('{busy_hi, AW'(0)});
   endtask

   task automatic pop_cmp(input int id, input logic [AW-1:0] addr);
      ev_t e;
      if (q[id].size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_%s cyc=%0d actual=1 required=0", qn(id), cyc);
         return;
      end
      e = q[id].pop_front();
      chk({qn(id), "_cyc"}, 64'(cyc), 64'(e.cyc));
      if (id == 0 || id == 2 || id == 4) chk({qn(id), "_addr"}, 64'(addr), 64'(e.addr));
   endtask

   always @(negedge clk) begin
      if (rst_prev) begin
         chk("reset_zero",
             {9'd0, mmu.Busy, mmu.Done, mmu.WeightRdEn, mmu.Load, mmu.InputRdEn, mmu.EN, mmu.OutValid,
              mmu.WeightRdAddr, mmu.InputRdAddr, mmu.OutAddr}, 64'd0);
      end else begin
         for (int j = 0; j < 6; j++) begin
            while (q[j].size() > 0 && q[j][0].cyc < cyc) begin
               checks++;
               failures++;
               $display("FAIL missed_%s cyc=%0d actual=absent required_cyc=%0d", qn(j), cyc, q[j][0].cyc);
               void'(q[j].pop_front());
            end
         end
         chk("busy", 64'(mmu.Busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
         if (mmu.WeightRdEn) pop_cmp(0, mmu.WeightRdAddr);
         if (mmu.Load)       pop_cmp(1, '0);
         if (mmu.InputRdEn)  pop_cmp(2, mmu.InputRdAddr);
         if (mmu.EN)         pop_cmp(3, '0);
         if (mmu.OutValid)   pop_cmp(4, mmu.OutAddr);
         if (mmu.Done)       pop_cmp(5, '0);
      end
      rst_prev = rst;
   end

   task automatic step(input bit st, input int n, input logic [AW-1:0] wb, input logic [AW-1:0] ib);
      mmu.Start      = st;
      mmu.NumRows    = AW'(n);
      mmu.WeightBase = wb;
      mmu.InputBase  = ib;
      if (st && !rst && cyc > busy_hi) push_job(cyc, n, wb, ib);
      @(posedge clk);
      #1;
      mmu.Start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) step(1'b0, 0, '0, '0);
   endtask

   task automatic do_reset(input int ncyc);
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int j = 0; j < 6; j++) q[j].delete();
      busy_lo = 1;
      busy_hi = 0;
      for (int j = 1; j < ncyc; j++) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   initial begin
      mmu.Start      = 1'b0;
      mmu.NumRows    = '0;
      mmu.WeightBase = '0;
      mmu.InputBase  = '0;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      idle(2);

      // Nominal job, ignored Starts at +6 and in DONE, then a back-to-back job.
      s = cyc;
      step(1'b1, 3, 16'h0010, 16'h0040);
      idle(5);
      step(1'b1, 7, 16'h1234, 16'h5678);
      idle(9);
      step(1'b1, 5, 16'h0AAA, 16'h0BBB);
      step(1'b1, 1, 16'h0200, 16'hFFFF);
      idle(20);

      step(1'b1, 0, 16'h0300, 16'h0400);
      idle(4);

      step(1'b1, 2, 16'hFFFE, 16'h0100);
      idle(22);

      // Abort in the middle of the weight preload.
      step(1'b1, 3, 16'h0020, 16'h0030);
      idle(1);
      do_reset(2);
      idle(2);

      for (int j = 0; j < 500; j++) begin
         if ($urandom_range(0, 120) == 0) do_reset(int'($urandom_range(1, 2)));
         else step(($urandom_range(0, 2) == 0), int'($urandom_range(0, 6)), AW'($urandom), AW'($urandom));
      end
      idle(40);

      for (int j = 0; j < 6; j++) chk({"leftover_", qn(j)}, 64'(q[j].size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
